// File: rtl/fcmp_pkg.sv
// Shared types and helpers for the shared single-precision FP compare unit.
package fcmp_pkg;

    localparam int               EXP_W   = 8;
    localparam int               FRAC_W  = 23;
    localparam logic [EXP_W-1:0] EXP_NAN = 8'hFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic unord;
        logic sign;
    } fcmp_res_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == EXP_NAN) && (x.frac != '0);
    endfunction

    function automatic logic is_zero(input fp32_t x);
        return (x.exp == '0) && (x.frac == '0);
    endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational classify + ordered compare + NaN-propagation sign for two fp32 operands.
module fcmp_core
    import fcmp_pkg::*;
(
    input  fp32_t     i_a,
    input  fp32_t     i_b,
    output fcmp_res_t o_res
);

    logic                    w_a_nan;
    logic                    w_b_nan;
    logic                    w_both_zero;
    logic [EXP_W+FRAC_W-1:0] w_mag_a;
    logic [EXP_W+FRAC_W-1:0] w_mag_b;

    assign w_a_nan     = is_nan(i_a);
    assign w_b_nan     = is_nan(i_b);
    assign w_both_zero = is_zero(i_a) && is_zero(i_b);
    assign w_mag_a     = {i_a.exp, i_a.frac};
    assign w_mag_b     = {i_b.exp, i_b.frac};

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_res       = '0;
        o_res.unord = w_a_nan | w_b_nan;

        if (!o_res.unord) begin
            if (w_both_zero) begin
                o_res.eq = 1'b1;
            end else if (i_a.sign != i_b.sign) begin
                o_res.lt = i_a.sign;
            end else if (!i_a.sign) begin
                o_res.lt = (w_mag_a < w_mag_b);
                o_res.eq = (w_mag_a == w_mag_b);
            end else begin
                // Sign-magnitude: for two negatives the larger magnitude is the smaller value.
                o_res.lt = (w_mag_a > w_mag_b);
                o_res.eq = (w_mag_a == w_mag_b);
            end
        end

        if (w_a_nan && w_b_nan) begin
            if (i_a.frac == i_b.frac)
                o_res.sign = i_a.sign & i_b.sign;
            else if (i_a.frac < i_b.frac)
                o_res.sign = i_b.sign;
            else
                o_res.sign = i_a.sign;
        end else if (w_b_nan) begin
            o_res.sign = i_b.sign;
        end else begin
            o_res.sign = i_a.sign;
        end
    end

endmodule

// File: rtl/fcmp_share_arb.sv
// Round-robin arbiter sharing one 2-stage FP compare pipeline among NREQ requesters.
// Optional FCMP_SHARE_ARB_STATS_EN adds saturating result/stall counters.
module fcmp_share_arb
    import fcmp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_opa,
    input  logic [NREQ*32-1:0] req_opb,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDW-1:0]     res_id,
    output logic               res_lt,
    output logic               res_eq,
    output logic               res_unord,
    output logic               res_sign
`ifdef FCMP_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]        stat_ops,
    output logic [15:0]        stat_stall
`endif
);

    logic [IDW-1:0]  r_ptr;
    logic            r_s1_valid;
    fp32_t           r_s1_a;
    fp32_t           r_s1_b;
    logic [IDW-1:0]  r_s1_id;
    logic            r_s2_valid;
    fcmp_res_t       r_s2_res;
    logic [IDW-1:0]  r_s2_id;

    logic            w_stall;
    logic            w_grant_en;
    logic            w_found;
    logic            w_xfer;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;
    logic [31:0]     w_sel_a;
    logic [31:0]     w_sel_b;
    int              w_idx;
    fcmp_res_t       w_core_res;

    // S1 can only be blocked by a stalled S2, so one stall term gates both stages and the grant.
    assign w_stall    = r_s2_valid & ~res_ready;
    assign w_grant_en = rst_n & ~w_stall;

    always_comb begin
        w_gnt    = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found        = 1'b1;
                w_gnt[w_idx]   = 1'b1;
                w_gnt_id       = IDW'(w_idx);
                w_sel_a        = req_opa[w_idx*32 +: 32];
                w_sel_b        = req_opb[w_idx*32 +: 32];
            end
        end
    end

    assign req_ready = w_grant_en ? w_gnt : '0;
    assign w_xfer    = w_grant_en & w_found;

    fcmp_core u_core (
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .o_res (w_core_res)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= IDW'(NREQ-1);
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_id    <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_ptr   <= w_gnt_id;
                r_s1_a  <= w_sel_a;
                r_s1_b  <= w_sel_b;
                r_s1_id <= w_gnt_id;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_res <= w_core_res;
                r_s2_id  <= r_s1_id;
            end
        end
    end

    assign res_valid = r_s2_valid;
    assign res_id    = r_s2_id;
    assign res_lt    = r_s2_res.lt;
    assign res_eq    = r_s2_res.eq;
    assign res_unord = r_s2_res.unord;
    assign res_sign  = r_s2_res.sign;

`ifdef FCMP_SHARE_ARB_STATS_EN
    logic [15:0] r_stat_ops;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ops   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (r_s2_valid && res_ready && (r_stat_ops != 16'hFFFF))
                r_stat_ops <= r_stat_ops + 16'd1;
            if (w_stall && (r_stat_stall != 16'hFFFF))
                r_stat_stall <= r_stat_stall + 16'd1;
        end
    end

    assign stat_ops   = r_stat_ops;
    assign stat_stall = r_stat_stall;
`endif

endmodule
